// File: rtl/mmul_commit_unit.sv
// rtl/mmul_commit_unit.sv - collects drained rows of C and writes them to scratchpad memory
// Optional rows_committed_o performance counter enabled by MMUL_COMMIT_PERF_CNT_EN.
module mmul_commit_unit #(
    parameter int SYS_ARRAY_SIZE = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [ADDR_WIDTH:0]                        commit_i,
    output logic                                       commit_ready_o,
    input  logic [SYS_ARRAY_SIZE*(DATA_WIDTH+1)-1:0]   drain_i,
    output logic [ADDR_WIDTH+SYS_ARRAY_SIZE*DATA_WIDTH:0] wr_o,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       err_o,
    output logic [31:0]                                rows_committed_o
);

    localparam int ROW_BITS = SYS_ARRAY_SIZE * DATA_WIDTH;
    localparam int ELEM_W   = DATA_WIDTH + 1;
    localparam int CNT_W    = (SYS_ARRAY_SIZE > 1) ? $clog2(SYS_ARRAY_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(SYS_ARRAY_SIZE - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ROW_BITS-1:0]   wr_row_q, wr_row_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                      commit_valid;
    logic [ADDR_WIDTH-1:0]     commit_dest;
    logic [SYS_ARRAY_SIZE-1:0] en_vec;
    logic [ROW_BITS-1:0]       row_data;
    logic                      row_full;
    logic                      row_any;

    assign commit_valid = commit_i[ADDR_WIDTH];
    assign commit_dest  = commit_i[ADDR_WIDTH-1:0];

    // Each drain element is {enable, data}; column 0 lands in the low byte of the row.
    always_comb begin
        en_vec   = '0;
        row_data = '0;
        for (int i = 0; i < SYS_ARRAY_SIZE; i++) begin
            en_vec[i]                            = drain_i[i*ELEM_W + DATA_WIDTH];
            row_data[i*DATA_WIDTH +: DATA_WIDTH] = drain_i[i*ELEM_W +: DATA_WIDTH];
        end
        row_full = &en_vec;
        row_any  = |en_vec;
    end

    always_comb begin
        state_d        = state_q;
        row_cnt_d      = row_cnt_q;
        dest_d         = dest_q;
        wr_addr_d      = wr_addr_q;
        wr_en_d        = 1'b0;
        wr_row_d       = wr_row_q;
        done_d         = 1'b0;
        err_d          = err_q;
        commit_ready_o = 1'b0;
        busy_o         = 1'b0;

        case (state_q)
            IDLE: begin
                commit_ready_o = 1'b1;
                if (commit_valid) begin
                    dest_d    = commit_dest;
                    row_cnt_d = '0;
                    err_d     = 1'b0;
                    state_d   = COLLECT;
                end
                // Stray drain data with no commit open is a protocol error and wins over the clear.
                if (row_any) begin
                    err_d = 1'b1;
                end
            end
            COLLECT: begin
                busy_o = 1'b1;
                if (row_full) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = dest_q + ADDR_WIDTH'(row_cnt_q);
                    wr_row_d  = row_data;
                    row_cnt_d = row_cnt_q + CNT_W'(1);
                    if (row_cnt_q == LAST_ROW) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (row_any) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            dest_q    <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            dest_q    <= dest_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_o   = {wr_addr_q, wr_en_q, wr_row_q};
    assign done_o = done_q;
    assign err_o  = err_q;

`ifdef MMUL_COMMIT_PERF_CNT_EN
    logic [31:0] rows_committed_q, rows_committed_d;

    // Counts alongside the registered write so the value tracks wr_o.en exactly.
    always_comb begin
        rows_committed_d = rows_committed_q;
        if (wr_en_d) begin
            rows_committed_d = rows_committed_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_committed_q <= '0;
        end else begin
            rows_committed_q <= rows_committed_d;
        end
    end

    assign rows_committed_o = rows_committed_q;
`else
    assign rows_committed_o = '0;
`endif

endmodule

// File: tb/tb_mmul_commit_unit.sv
// tb/tb_mmul_commit_unit.sv - directed self-checking bench for mmul_commit_unit
module tb_mmul_commit_unit;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 10;
    localparam int RB  = N * DW;
    localparam int EW  = DW + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [AW:0]          commit_i = '0;
    logic                 commit_ready_o;
    logic [N*EW-1:0]      drain_i = '0;
    logic [AW+RB:0]       wr_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic [31:0]          rows_committed_o;

    int checks   = 0;
    int failures = 0;

    mmul_commit_unit #(
        .SYS_ARRAY_SIZE(N),
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .commit_i        (commit_i),
        .commit_ready_o  (commit_ready_o),
        .drain_i         (drain_i),
        .wr_o            (wr_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .rows_committed_o(rows_committed_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*EW-1:0] make_row(input int r, input logic [N-1:0] mask);
        logic [N*EW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i*EW +: EW] = {mask[i], 8'(r*4 + i)};
        end
        return v;
    endfunction

    function automatic logic [RB-1:0] exp_row(input int r);
        logic [RB-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*DW +: DW] = 8'(r*4 + i);
        end
        return v;
    endfunction

    task automatic start_commit(input logic [AW-1:0] dest);
        commit_i = {1'b1, dest};
        tick();
        commit_i = '0;
        check("accept_busy", busy_o, 1'b1);
        check("accept_ready", commit_ready_o, 1'b0);
    endtask

    // Drives four rows with 'gap' idle cycles between them and checks each write one cycle later.
    task automatic run_rows(input logic [AW-1:0] dest, input int gap);
        for (int r = 0; r < N; r++) begin
            drain_i = make_row(r, 4'hF);
            tick();
            drain_i = '0;
            check("wr_en", wr_o[RB], 1'b1);
            check("wr_addr", wr_o[AW+RB:RB+1], AW'(dest + AW'(r)));
            check("wr_row", wr_o[RB-1:0], exp_row(r));
            check("done", done_o, (r == N-1));
            if (r < N-1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("gap_wr_en", wr_o[RB], 1'b0);
                    check("gap_busy", busy_o, 1'b1);
                    check("gap_err", err_o, 1'b0);
                end
            end
        end
        check("end_ready", commit_ready_o, 1'b1);
        check("end_busy", busy_o, 1'b0);
        tick();
        check("post_wr_en", wr_o[RB], 1'b0);
        check("post_done", done_o, 1'b0);
    endtask

    initial begin
        #12;
        check("rst_wr", wr_o, '0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_cnt", rows_committed_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_ready", commit_ready_o, 1'b1);

        // Basic back-to-back commit
        start_commit(10'h010);
        run_rows(10'h010, 0);
        check("basic_err", err_o, 1'b0);

        // Gapped rows
        start_commit(10'h010);
        run_rows(10'h010, 2);

        // Address wrap
        start_commit(10'd1022);
        run_rows(10'd1022, 0);

        // Enables while idle, then cleared by the next commit
        drain_i = make_row(0, 4'h1);
        tick();
        drain_i = '0;
        check("idle_err", err_o, 1'b1);
        check("idle_wr_en", wr_o[RB], 1'b0);
        start_commit(10'h100);
        check("clear_err", err_o, 1'b0);

        // Partial row: no write, row count held
        drain_i = make_row(9, 4'h7);
        tick();
        drain_i = '0;
        check("partial_wr_en", wr_o[RB], 1'b0);
        check("partial_err", err_o, 1'b1);
        run_rows(10'h100, 0);

        // Reset after two rows of four
        start_commit(10'h020);
        for (int r = 0; r < 2; r++) begin
            drain_i = make_row(r, 4'hF);
            tick();
            check("pre_rst_addr", wr_o[AW+RB:RB+1], AW'(10'h020 + r));
        end
        drain_i = make_row(2, 4'hF);
        rst = 1'b1;
        #1;
        check("midrst_wr_en", wr_o[RB], 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_ready", commit_ready_o, 1'b1);
        drain_i = '0;
        tick();
        rst = 1'b0;
        start_commit(10'h040);
        run_rows(10'h040, 0);

        // Held commit across the last-row cycle, with counter from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_commit(10'h080);
        for (int r = 0; r < N; r++) begin
            drain_i = make_row(r, 4'hF);
            if (r == N-1) commit_i = {1'b1, 10'h0C0};
            tick();
            check("hold_addr", wr_o[AW+RB:RB+1], AW'(10'h080 + r));
        end
        drain_i = '0;
        check("hold_done", done_o, 1'b1);
        check("hold_not_yet", busy_o, 1'b0);
        tick();
        commit_i = '0;
        check("hold_accepted", busy_o, 1'b1);
        check("hold_done_clr", done_o, 1'b0);
        run_rows(10'h0C0, 0);
`ifdef MMUL_COMMIT_PERF_CNT_EN
        check("rows_committed", rows_committed_o, 32'd8);
`else
        check("rows_committed", rows_committed_o, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmul_commit_unit.md
Name: mmul_commit_unit

Overview:
Write-back end of the matrix-multiply datapath. It accepts a commit command (ctrl_commit_t) from the controller and collects drained result rows of C (drain_data_t, one per column) from the systolic array. Each complete row is packed and written to the scratchpad memory as a data_wire_t at consecutive addresses starting at dest. It is the mirror of the fetch/feed path: the feed path reads rows from memory and produces systolic_feed_t, while this block consumes array output and writes rows back to memory.

Parameters:
SYS_ARRAY_SIZE, common_pkg::SYS_ARRAY_SIZE (4), number of columns per row and rows per matrix
DATA_WIDTH, common_pkg::DATA_WIDTH (8), element width in bits
ADDR_WIDTH, common_pkg::ADDR_WIDTH (10), memory address width

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
commit_i  in  1+ADDR_WIDTH  ctrl_commit_t {valid, dest}
commit_ready_o  out  1  high when a commit can be accepted
drain_i  in  SYS_ARRAY_SIZE*(DATA_WIDTH+1)  drain_data_t array; element i is column i
wr_o  out  ADDR_WIDTH+1+ROW_BITS  data_wire_t {addr, en, row} to memory write port
busy_o  out  1  a commit is in progress
done_o  out  1  one-cycle pulse issued with the last row write
err_o  out  1  sticky protocol-error flag
rows_committed_o  out  32  countn_t performance counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, row_cnt=0, dest_q=0.
  - wr_o all zero (en=0), done_o=0, err_o=0, busy_o=0, rows_committed_o=0.
  - commit_ready_o=1 once reset is released.
  - Asserting rst mid-commit aborts it immediately. No further writes are issued and the partial matrix stays in memory as is.
- States: IDLE, COLLECT.
- IDLE:
  - commit_ready_o=1, busy_o=0.
  - A commit is accepted when commit_i.valid && commit_ready_o. On acceptance: dest_q<=commit_i.dest, row_cnt<=0, err_o<=0, state->COLLECT.
- COLLECT:
  - commit_ready_o=0, busy_o=1. commit_i.valid is ignored (no queueing).
  - Row-valid: all SYS_ARRAY_SIZE drain_i[i].enable bits are high in the same cycle.
  - On a valid row at cycle t, the write is registered and appears at t+1:
    - wr_o.en=1
    - wr_o.addr=dest_q+row_cnt, truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH (e.g. dest 1022 with 4 rows writes 1022, 1023, 0, 1).
    - wr_o.row[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i] = drain_i[i].data
    - row_cnt increments.
  - When the valid row is row SYS_ARRAY_SIZE-1: done_o=1 at t+1, coincident with that write. The state returns to IDLE at t+1, so the next commit can be accepted from t+1.
  - Partial row (some but not all enables high): no write, row_cnt unchanged, err_o<=1.
  - No enables high: idle cycle, no effect. Gaps between rows are allowed.
- wr_o.en is 0 in every cycle without a registered write. wr_o.addr and wr_o.row hold their last values when en=0.
- Any enable high while in IDLE: data is dropped and err_o<=1. err_o clears only on reset or on an accepted commit.
- Same cycle as the last row capture: commit_ready_o is still 0, so a commit presented that cycle is not accepted. It must be held and is accepted one cycle later.
- Throughput: one row per cycle; back-to-back rows are fully supported.

Optional Feature:
Macro: MMUL_COMMIT_PERF_CNT_EN
- Defined: rows_committed_o is a 32-bit counter.
  - Increments by 1 on each cycle wr_o.en=1.
  - Wraps from 2^32-1 to 0.
  - Resets to 0 and is not cleared by commits.
- Undefined: rows_committed_o is tied to 0 and no counter flops are synthesized. All other behaviour is identical.

Test Plan:
- Basic commit:
  - Stimulus: reset, commit dest=0x010, then 4 back-to-back full rows with column data {r*4+i}.
  - Required: wr_o.en=1 for 4 consecutive cycles, each one cycle after its row. Addresses 0x010..0x013, row r packed with column 0 in the LSB byte. done_o pulses with the 4th write; commit_ready_o=1 the following cycle.
- Gapped rows:
  - Stimulus: same as basic commit, but 2 idle cycles (all enables 0) between rows.
  - Required: addresses and data are identical, only the timing is stretched; busy_o stays 1 throughout; err_o=0.
- Address wrap:
  - Stimulus: commit dest=1022.
  - Required: writes to 1022, 1023, 0, 1.
- Protocol errors:
  - Partial enables (3 of 4) in COLLECT: no write and err_o=1.
  - Enables high while IDLE: err_o=1.
  - The next accepted commit clears err_o to 0.
- Reset mid-operation:
  - Stimulus: assert rst after row 2 of 4.
  - Required: wr_o.en=0 immediately, state IDLE, busy_o=0. A new commit then writes from its own dest with row_cnt restarting at 0.
- Boundary handshake and counter (with MMUL_COMMIT_PERF_CNT_EN):
  - Stimulus: hold commit_i.valid high during the last-row cycle, then run 2 full commits.
  - Required: the held commit is accepted one cycle after done_o; rows_committed_o=8.
  - Without the macro: rows_committed_o=0 throughout.
